// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared types and constants for the iterative CORDIC sequencer:
//               FSM state encoding, mode encodings, the arctangent table
//               (Q2.30 radians) and the inverse CORDIC gain.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Inverse of the asymptotic CORDIC gain (~0.60725), Q2.30.
  // Callers pre-scale with this; the sequencer itself never compensates gain.
  localparam logic [31:0] K_INV_Q30 = 32'h26DD3B6A;

  localparam logic MODE_ROTATION  = 1'b0;  // drive z toward 0
  localparam logic MODE_VECTORING = 1'b1;  // drive y toward 0

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SHX  = 3'd1,
    ST_SHY  = 3'd2,
    ST_UPD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // atan(2^-i) scaled by 2^30. The tail entries collapse to a few LSBs.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
    32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
    32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
    32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
    32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
    32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
    32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// Module      : cordic_atan_rom
// Description : Combinational lookup of atan(2^-idx) in Q2.30 radians.
// Ports       : idx   in  5  iteration index
//               value out 32 arctangent constant
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [4:0]  idx,
  output logic [31:0] value
);

  assign value = ATAN_TABLE[idx];

endmodule
`default_nettype wire

// File: rtl/cordic_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cordic_iter_ctrl
// Description : Iterative CORDIC sequencer. Runs ITER micro-rotations on x/y/z
//               by time-multiplexing one external combinational barrel
//               shifter: x is shifted in SHX, y in SHY, and the add/sub
//               update happens in UPD. Rotation and vectoring modes.
// Ports       : clk, rst_n (sync, active-low)
//               start, mode, x_in, y_in, z_in      - command (taken in IDLE)
//               busy, done, x_out, y_out, z_out     - status / results
//               sh_data_in, sh_rightleft, sh_arith,
//               sh_amount, sh_data_out              - shared shifter port
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER = 16,  // 1..32, limited by the 5-bit shift amount
  parameter int W    = 32   // fixed to match the shifter
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic [W-1:0] sh_data_in,
  output logic         sh_rightleft,
  output logic         sh_arith,
  output logic [4:0]   sh_amount,
  input  logic [W-1:0] sh_data_out
);

  state_t       state;
  logic         mode_q;
  logic [4:0]   iter_idx;
  logic [W-1:0] x, y, z;
  logic [W-1:0] xs, ys;

  logic [W-1:0] atan_val;
  logic         dir_pos;
  logic         last_iter;
  logic [W-1:0] x_upd, y_upd, z_upd;

  // Always an arithmetic right shift: x*2^-i, y*2^-i with sign fill.
  assign sh_rightleft = 1'b0;
  assign sh_arith     = 1'b1;

  cordic_atan_rom u_atan_rom (
    .idx   (iter_idx),
    .value (atan_val)
  );

  assign last_iter = (iter_idx == 5'(ITER - 1));

  // d = +1 rotates counter-clockwise. Rotation mode steers z toward zero,
  // vectoring mode steers y toward zero from whichever side it sits on.
  always_comb begin
    dir_pos = (mode_q == MODE_VECTORING) ? y[W-1] : ~z[W-1];
    if (dir_pos) begin
      x_upd = x - ys;
      y_upd = y + xs;
      z_upd = z - atan_val;
    end else begin
      x_upd = x + ys;
      y_upd = y - xs;
      z_upd = z + atan_val;
    end
  end

  // The shifter operand is registered one state ahead so it is already
  // stable when SHX/SHY sample sh_data_out in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_ROTATION;
      iter_idx   <= 5'd0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      xs         <= '0;
      ys         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      sh_data_in <= '0;
      sh_amount  <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x          <= x_in;
            y          <= y_in;
            z          <= z_in;
            mode_q     <= mode;
            iter_idx   <= 5'd0;
            busy       <= 1'b1;
            sh_data_in <= x_in;
            sh_amount  <= 5'd0;
            state      <= ST_SHX;
          end
        end
        ST_SHX: begin
          xs         <= sh_data_out;
          sh_data_in <= y;
          state      <= ST_SHY;
        end
        ST_SHY: begin
          ys         <= sh_data_out;
          sh_data_in <= '0;
          state      <= ST_UPD;
        end
        ST_UPD: begin
          x <= x_upd;
          y <= y_upd;
          z <= z_upd;
          if (last_iter) begin
            // Results are published on entry to DONE so they are valid
            // during the single done cycle and held afterwards.
            x_out     <= x_upd;
            y_out     <= y_upd;
            z_out     <= z_upd;
            done      <= 1'b1;
            busy      <= 1'b0;
            sh_amount <= 5'd0;
            state     <= ST_DONE;
          end else begin
            iter_idx   <= iter_idx + 5'd1;
            sh_data_in <= x_upd;
            sh_amount  <= iter_idx + 5'd1;
            state      <= ST_SHX;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_iter_ctrl
// Description : Scoreboard bench for cordic_iter_ctrl with a behavioural
//               model of the shared barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_iter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] x_in, y_in, z_in;
  logic        busy, done;
  logic [31:0] x_out, y_out, z_out;
  logic [31:0] sh_data_in;
  logic        sh_rightleft, sh_arith;
  logic [4:0]  sh_amount;
  logic [31:0] sh_data_out;

  cordic_iter_ctrl #(.ITER(16), .W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .busy         (busy),
    .done         (done),
    .x_out        (x_out),
    .y_out        (y_out),
    .z_out        (z_out),
    .sh_data_in   (sh_data_in),
    .sh_rightleft (sh_rightleft),
    .sh_arith     (sh_arith),
    .sh_amount    (sh_amount),
    .sh_data_out  (sh_data_out)
  );

  // Shared shifter model
  always_comb begin
    if (sh_rightleft)  sh_data_out = sh_data_in << sh_amount;
    else if (sh_arith) sh_data_out = $signed(sh_data_in) >>> sh_amount;
    else               sh_data_out = sh_data_in >> sh_amount;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  bit rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  typedef struct {
    int          base;
    logic [31:0] x0, y0, x1, y1;
    logic [31:0] ex, ey, ez;
    int          tx, ty, tz;
    bit          chk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint absdiff(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d < 0) ? -d : d;
  endfunction

  // Monitor: checks per-cycle protocol against the active scoreboard entry.
  int k;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rst_edge) begin
        check("rst_flags", busy === 1'b0 && done === 1'b0, {30'd0, busy, done}, 32'd0);
        check("rst_results", {x_out, y_out, z_out} === 96'd0, x_out | y_out | z_out, 32'd0);
        check("rst_shifter", sh_data_in === 32'd0 && sh_amount === 5'd0,
              sh_data_in | {27'd0, sh_amount}, 32'd0);
      end
      check("sh_ctrl", sh_rightleft === 1'b0 && sh_arith === 1'b1,
            {30'd0, sh_rightleft, sh_arith}, 32'd1);
      if (q.size() > 0 && cyc > q[0].base) begin
        k = cyc - q[0].base;
        if (k < 49) begin
          check("busy_phase", busy === 1'b1 && done === 1'b0, {30'd0, busy, done}, 32'd2);
          if (k % 3 != 0)
            check("sh_amount", sh_amount === 5'((k - 1) / 3), {27'd0, sh_amount}, 32'((k - 1) / 3));
          if (k == 1) check("shx0_operand", sh_data_in === q[0].x0, sh_data_in, q[0].x0);
          if (k == 2) check("shy0_operand", sh_data_in === q[0].y0, sh_data_in, q[0].y0);
          if (k == 4) check("shx1_operand", sh_data_in === q[0].x1, sh_data_in, q[0].x1);
          if (k == 5) check("shy1_operand", sh_data_in === q[0].y1, sh_data_in, q[0].y1);
        end else begin
          check("done_at_49", done === 1'b1, {31'd0, done}, 32'd1);
          check("busy_off_done", busy === 1'b0, {31'd0, busy}, 32'd0);
          check("sh_idle_done", sh_data_in === 32'd0 && sh_amount === 5'd0,
                sh_data_in | {27'd0, sh_amount}, 32'd0);
          if (q[0].chk) begin
            check("x_out", !$isunknown(x_out) && absdiff(x_out, q[0].ex) <= q[0].tx, x_out, q[0].ex);
            check("y_out", !$isunknown(y_out) && absdiff(y_out, q[0].ey) <= q[0].ty, y_out, q[0].ey);
            check("z_out", !$isunknown(z_out) && absdiff(z_out, q[0].ez) <= q[0].tz, z_out, q[0].ez);
          end else begin
            check("results_known", !$isunknown({x_out, y_out, z_out}), x_out, x_out ^ x_out);
          end
          void'(q.pop_front());
        end
      end else begin
        check("idle_flags", busy === 1'b0 && done === 1'b0, {30'd0, busy, done}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a command in the current cycle (cycle 0) and records the expected
  // response. First-step operands come from the direction rule at shift 0.
  task automatic issue(input logic m, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic [31:0] ex,
                       input logic [31:0] ey, input logic [31:0] ez,
                       input int tx, input int ty, input int tz, input bit chk);
    exp_t e;
    bit   d;
    start = 1'b1;
    mode  = m;
    x_in  = x;
    y_in  = y;
    z_in  = z;
    d = m ? y[31] : ~z[31];
    e.base = cyc;
    e.x0 = x;
    e.y0 = y;
    e.x1 = d ? x - y : x + y;
    e.y1 = d ? y + x : y - x;
    e.ex = ex; e.ey = ey; e.ez = ez;
    e.tx = tx; e.ty = ty; e.tz = tz;
    e.chk = chk;
    q.push_back(e);
  endtask

  task automatic junk_start();
    start = 1'b1;
    mode  = ~mode;
    x_in  = 32'h40000000;
    y_in  = 32'h40000000;
    z_in  = 32'h10000000;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 200 && q.size() > 0; n++) tick();
    check("op_completed", q.size() == 0, 32'(q.size()), 32'd0);
    tick();
  endtask

  localparam int T14 = 1 << 16;  // 2^-14 in Q2.30
  localparam int T13 = 1 << 17;  // 2^-13 in Q2.30

  int b;
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    x_in  = '0;
    y_in  = '0;
    z_in  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Rotation by pi/4, with a start ignored while busy and one in DONE
    b = cyc;
    issue(1'b0, 32'h26DD3B6A, 32'h0, 32'h3243F6A9,
          32'h2D413CCD, 32'h2D413CCD, 32'h0, T14, T14, T14, 1'b1);
    tick();
    start = 1'b0;
    while (cyc < b + 10) tick();
    junk_start();
    tick();
    start = 1'b0;
    while (cyc < b + 49) tick();
    junk_start();
    tick();
    // Vectoring (0.5, 0.5) accepted at cycle 50
    issue(1'b1, 32'h20000000, 32'h20000000, 32'h0,
          32'h4A861BC3, 32'h0, 32'h3243F6A9, T13, T14, T14, 1'b1);
    tick();
    start = 1'b0;
    wait_empty();

    // Rotation with z = 0 (first step takes d = +1)
    issue(1'b0, 32'h26DD3B6A, 32'h0, 32'h0,
          32'h40000000, 32'h0, 32'h0, T14, T14, T14, 1'b1);
    tick();
    start = 1'b0;
    wait_empty();

    // Reset in the middle of an operation, then a fresh command
    b = cyc;
    issue(1'b0, 32'h26DD3B6A, 32'h0, 32'h1921FB54,
          32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b1);
    tick();
    start = 1'b0;
    while (cyc < b + 20) tick();
    rst_n = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 32'h26DD3B6A, 32'h0, 32'hCDBC0957,
          32'h2D413CCD, 32'hD2BEC333, 32'h0, T14, T14, T14, 1'b1);
    tick();
    start = 1'b0;
    wait_empty();

    // Vectoring with most-negative y: timing and known outputs only
    issue(1'b1, 32'h0, 32'h80000000, 32'h0,
          32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
    tick();
    start = 1'b0;
    wait_empty();

    // Vectoring from below the axis: angle converges to -pi/4
    issue(1'b1, 32'h20000000, 32'hE0000000, 32'h0,
          32'h4A861BC3, 32'h0, 32'hCDBC0957, T13, T14, T14, 1'b1);
    tick();
    start = 1'b0;
    wait_empty();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
